// File: rtl/lzc_pkg.sv
// lzc_pkg: shared FSM state type and chunk bit-reversal helper for the sequential normalizer
package lzc_pkg;

    typedef enum logic [1:0] {IDLE, SCAN, SHIFT, DONE} lzc_state_e;

    localparam int LZC_MAX_W = 256;

    function automatic logic [LZC_MAX_W-1:0] chunk_reverse(input logic [LZC_MAX_W-1:0] v, input int w);
        chunk_reverse = '0;
        for (int i = 0; i < LZC_MAX_W; i++)
            if (i < w) chunk_reverse[i] = v[w-1-i];
    endfunction

endpackage

// File: rtl/leading_zero_count.sv
// leading_zero_count: narrow counter of zeros from bit 0 upward, plus all-zero flag
module leading_zero_count #(
    parameter  int WIDTH = 16,
    localparam int CB    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] data_i,
    output logic [CB-1:0]    count_o,
    output logic             zero_o
);

    // lowest set bit wins, scanning from the top so the last hit is the smallest index
    always_comb begin
        count_o = '0;
        for (int i = WIDTH - 1; i >= 0; i--)
            if (data_i[i]) count_o = CB'(i);
        zero_o = ~|data_i;
    end

endmodule

// File: rtl/lzc_seq_normalizer.sv
// lzc_seq_normalizer: chunk-serial leading-zero count followed by a single barrel shift
module lzc_seq_normalizer
    import lzc_pkg::*;
#(
    parameter  int DATA_WIDTH  = 64,
    parameter  int CHUNK_WIDTH = 16,
    localparam int NUM_CHUNKS  = DATA_WIDTH / CHUNK_WIDTH,
    localparam int COUNT_BITS  = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] norm_o,
    output logic [COUNT_BITS-1:0] count_o,
    output logic                  allzero_o
);

    localparam int IDX_BITS = NUM_CHUNKS > 1 ? $clog2(NUM_CHUNKS) : 1;
    localparam int SUB_BITS = $clog2(CHUNK_WIDTH);

    lzc_state_e              r_state, w_state_nxt;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [IDX_BITS-1:0]     r_idx;
    logic [COUNT_BITS-1:0]   r_acc;
    logic [DATA_WIDTH-1:0]   r_norm;
    logic [COUNT_BITS-1:0]   r_count;
    logic                    r_allzero;
    logic [CHUNK_WIDTH-1:0]  w_chunks [NUM_CHUNKS];
    logic [CHUNK_WIDTH-1:0]  w_rev;
    logic [SUB_BITS-1:0]     w_sub_cnt;
    logic                    w_zero;
    logic                    w_last;

    genvar g;
    for (g = 0; g < NUM_CHUNKS; g++) begin : g_chunk
        assign w_chunks[g] = r_data[DATA_WIDTH-1-g*CHUNK_WIDTH -: CHUNK_WIDTH];
    end

    assign w_rev   = CHUNK_WIDTH'(chunk_reverse(LZC_MAX_W'(w_chunks[r_idx]), CHUNK_WIDTH));
    assign w_last  = r_idx == IDX_BITS'(NUM_CHUNKS - 1);
    assign ready_o = (r_state == IDLE) && !rst_i;
    assign valid_o = r_state == DONE;
    assign norm_o    = r_norm;
    assign count_o   = r_count;
    assign allzero_o = r_allzero;

    leading_zero_count #(.WIDTH(CHUNK_WIDTH)) u_lzc (
        .data_i  (w_rev),
        .count_o (w_sub_cnt),
        .zero_o  (w_zero)
    );

    // next-state decode; flush overrides everything and returns to IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:  w_state_nxt = valid_i ? SCAN : IDLE;
            SCAN:  w_state_nxt = !w_zero ? SHIFT : (w_last ? DONE : SCAN);
            SHIFT: w_state_nxt = DONE;
            DONE:  w_state_nxt = ready_i ? IDLE : DONE;
            default: w_state_nxt = IDLE;
        endcase
        if (flush_i) w_state_nxt = IDLE;
    end

    // state register
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // operand capture, count accumulation and result registers; held on flush
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_data    <= '0;
            r_idx     <= '0;
            r_acc     <= '0;
            r_norm    <= '0;
            r_count   <= '0;
            r_allzero <= 1'b0;
        end else if (!flush_i) begin
            case (r_state)
                IDLE: if (valid_i) begin
                    r_data <= data_i;
                    r_idx  <= '0;
                    r_acc  <= '0;
                end
                SCAN: if (!w_zero) begin
                    r_acc <= r_acc + COUNT_BITS'(w_sub_cnt);
                end else if (w_last) begin
                    r_count   <= COUNT_BITS'(DATA_WIDTH);
                    r_allzero <= 1'b1;
                    r_norm    <= '0;
                end else begin
                    r_acc <= r_acc + COUNT_BITS'(CHUNK_WIDTH);
                    r_idx <= r_idx + IDX_BITS'(1);
                end
                SHIFT: begin
                    r_norm    <= r_data << r_acc;
                    r_count   <= r_acc;
                    r_allzero <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
